// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit BCD display scanner with double-buffered digits,
// leading-zero blanking and a sticky non-BCD error flag.
module seven_seg_scanner #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  bcd_out,
    output logic [3:0]  dig_en_n,
    output logic        frame_done,
    output logic        bcd_err
);

    localparam int unsigned PcW = $clog2(PRESCALE);
    localparam logic [PcW-1:0] PcMax = PcW'(PRESCALE - 1);

    logic [PcW-1:0] pc_q;
    logic [1:0]     idx_q;
    logic [15:0]    pending_q;
    logic [15:0]    shadow_q;
    logic           pend_v_q;

    logic           tick;
    logic           frame_bound;
    logic [3:0]     cur_digit;
    logic [3:0]     lz_blank;
    logic           digit_bad;
    logic           slot_blank;

    always_comb begin
        tick        = (pc_q == PcMax);
        frame_bound = tick && (idx_q == 2'd3);
        cur_digit   = shadow_q[{idx_q, 2'b00} +: 4];
        // lz_blank[i]: digits i..3 are all zero; digit 0 is never a leading zero
        lz_blank[3] = (shadow_q[15:12] == 4'd0);
        lz_blank[2] = lz_blank[3] && (shadow_q[11:8] == 4'd0);
        lz_blank[1] = lz_blank[2] && (shadow_q[7:4] == 4'd0);
        lz_blank[0] = 1'b0;
        digit_bad   = (cur_digit > 4'd9);
        slot_blank  = digit_bad || (blank_lz && lz_blank[idx_q]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= '0;
            idx_q      <= 2'd0;
            pending_q  <= 16'h0000;
            shadow_q   <= 16'h0000;
            pend_v_q   <= 1'b0;
            bcd_out    <= 4'h0;
            dig_en_n   <= 4'b1111;
            frame_done <= 1'b0;
            bcd_err    <= 1'b0;
        end else begin
            pc_q       <= tick ? '0 : pc_q + 1'b1;
            frame_done <= frame_bound;

            // Slot output latches the digit at the current index, then the index moves on
            if (tick) begin
                idx_q <= idx_q + 2'd1;
                if (slot_blank) begin
                    bcd_out  <= 4'hF;
                    dig_en_n <= 4'b1111;
                end else begin
                    bcd_out  <= cur_digit;
                    dig_en_n <= ~(4'b0001 << idx_q);
                end
                if (digit_bad) begin
                    bcd_err <= 1'b1;
                end
            end

            // Shadow only changes at a frame boundary so a frame never tears
            if (load && frame_bound) begin
                shadow_q <= digits_in;
                pend_v_q <= 1'b0;
            end else if (load) begin
                pending_q <= digits_in;
                pend_v_q  <= 1'b1;
            end else if (frame_bound && pend_v_q) begin
                shadow_q <= pending_q;
                pend_v_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed, table-driven bench for seven_seg_scanner with PRESCALE = 4.
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  bcd_out;
    logic [3:0]  dig_en_n;
    logic        frame_done;
    logic        bcd_err;

    int checks = 0;
    int errors = 0;
    int c = 0;

    seven_seg_scanner #(.PRESCALE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits_in (digits_in),
        .load      (load),
        .blank_lz  (blank_lz),
        .bcd_out   (bcd_out),
        .dig_en_n  (dig_en_n),
        .frame_done(frame_done),
        .bcd_err   (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] digits;
        logic        blank;
        logic [15:0] bcds;  // slot s expected bcd_out in nibble s
        logic [15:0] ens;   // slot s expected dig_en_n in nibble s
        logic [3:0]  errs;  // slot s expected bcd_err in bit s
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic run_to(input int n);
        while (c < n) step();
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        c = 0;
    endtask

    task automatic load_now(input logic [15:0] d);
        digits_in = d;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic check_slot(input string name, input int at, input logic [3:0] b,
                              input logic [3:0] e);
        run_to(at);
        check({name, " bcd"}, 16'(bcd_out), 16'(b));
        check({name, " en"}, 16'(dig_en_n), 16'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [1:0] seen;

        vecs[0] = '{16'h1234, 1'b0, 16'h1234, 16'h7BDE, 4'b0000};
        vecs[1] = '{16'h0047, 1'b1, 16'hFF47, 16'hFFDE, 4'b0000};
        vecs[2] = '{16'h0000, 1'b1, 16'hFFF0, 16'hFFFE, 4'b0000};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000, 16'h7BDE, 4'b0000};
        vecs[4] = '{16'h00A0, 1'b0, 16'h00F0, 16'h7BFE, 4'b1110};
        vecs[5] = '{16'h0305, 1'b1, 16'hF305, 16'hFBDE, 4'b0000};
        vecs[6] = '{16'h1000, 1'b1, 16'h1000, 16'h7BDE, 4'b0000};
        vecs[7] = '{16'hB009, 1'b1, 16'hF009, 16'hFBDE, 4'b1000};

        rst_n = 1'b0;
        load = 1'b0;
        blank_lz = 1'b0;
        digits_in = 16'h0000;
        do_reset();
        check("reset bcd", 16'(bcd_out), 16'h0);
        check("reset en", 16'(dig_en_n), 16'hF);
        check("reset fd", 16'(frame_done), 16'h0);
        check("reset err", 16'(bcd_err), 16'h0);

        // Table: load at first edge, shadow swaps at c=16, second frame slots at 20..32
        for (int i = 0; i < 8; i++) begin
            blank_lz = vecs[i].blank;
            do_reset();
            load_now(vecs[i].digits);
            run_to(15);
            check($sformatf("v%0d fd pre", i), 16'(frame_done), 16'h0);
            run_to(16);
            check($sformatf("v%0d fd", i), 16'(frame_done), 16'h1);
            run_to(17);
            check($sformatf("v%0d fd post", i), 16'(frame_done), 16'h0);
            for (int s = 0; s < 4; s++) begin
                check_slot($sformatf("v%0d slot%0d", i, s), 20 + 4 * s,
                           vecs[i].bcds[4*s +: 4], vecs[i].ens[4*s +: 4]);
                check($sformatf("v%0d slot%0d err", i, s), 16'(bcd_err),
                      16'(vecs[i].errs[s]));
                run_to(23 + 4 * s);
                check($sformatf("v%0d slot%0d hold", i, s), 16'(bcd_out),
                      16'(vecs[i].bcds[4*s +: 4]));
            end
        end

        // Back-to-back loads mid-frame: current frame keeps 1s, next shows the last load
        blank_lz = 1'b0;
        do_reset();
        load_now(16'h1111);
        run_to(20);
        check_slot("b2b f2 s0", 20, 4'h1, 4'hE);
        load_now(16'h2222);
        step();
        load_now(16'h3333);
        check_slot("b2b f2 s1", 24, 4'h1, 4'hD);
        check_slot("b2b f2 s2", 28, 4'h1, 4'hB);
        check_slot("b2b f2 s3", 32, 4'h1, 4'h7);
        check_slot("b2b f3 s0", 36, 4'h3, 4'hE);
        check_slot("b2b f3 s3", 48, 4'h3, 4'h7);

        // Load on the boundary cycle writes shadow directly and leaves nothing pending
        do_reset();
        load_now(16'h1111);
        run_to(31);
        load_now(16'h5555);
        check_slot("bnd f2 s3", 32, 4'h1, 4'h7);
        check_slot("bnd f3 s0", 36, 4'h5, 4'hE);
        check_slot("bnd f3 s3", 48, 4'h5, 4'h7);
        check_slot("bnd f4 s0", 52, 4'h5, 4'hE);
        check_slot("bnd f4 s2", 60, 4'h5, 4'hB);

        // blank_lz change applies from the next slot output
        do_reset();
        load_now(16'h0047);
        check_slot("lzchg s1", 24, 4'h4, 4'hD);
        run_to(26);
        blank_lz = 1'b1;
        check_slot("lzchg s2", 28, 4'hF, 4'hF);
        run_to(34);
        blank_lz = 1'b0;
        check_slot("lzchg f3 s0", 36, 4'h7, 4'hE);
        check_slot("lzchg f3 s2", 44, 4'h0, 4'hB);

        // Sticky error survives valid loads until reset
        do_reset();
        load_now(16'h00A0);
        run_to(20);
        check("sticky pre", 16'(bcd_err), 16'h0);
        run_to(24);
        check("sticky rise", 16'(bcd_err), 16'h1);
        run_to(26);
        load_now(16'h1234);
        check_slot("sticky f3 s1", 40, 4'h3, 4'hD);
        check("sticky f3 err", 16'(bcd_err), 16'h1);
        run_to(52);
        check("sticky f4 err", 16'(bcd_err), 16'h1);
        do_reset();
        check("sticky cleared", 16'(bcd_err), 16'h0);
        run_to(40);
        check("sticky stays 0", 16'(bcd_err), 16'h0);

        // Reset during slot 2 with a pending load; load asserted while in reset
        do_reset();
        load_now(16'h1234);
        run_to(26);
        load_now(16'h9876);
        run_to(29);
        check("midrst slot2", 16'(bcd_out), 16'h2);
        rst_n = 1'b0;
        digits_in = 16'h5555;
        load = 1'b1;
        step();
        step();
        check("midrst bcd", 16'(bcd_out), 16'h0);
        check("midrst en", 16'(dig_en_n), 16'hF);
        check("midrst fd", 16'(frame_done), 16'h0);
        check("midrst err", 16'(bcd_err), 16'h0);
        rst_n = 1'b1;
        load = 1'b0;
        c = 0;
        pulses = 0;
        seen = 2'b00;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (frame_done) begin
                pulses++;
                if (c == 16) seen[0] = 1'b1;
                if (c == 32) seen[1] = 1'b1;
            end
            if (c == 3) check("first slot pre en", 16'(dig_en_n), 16'hF);
            if (c == 4) begin
                check("first slot bcd", 16'(bcd_out), 16'h0);
                check("first slot en", 16'(dig_en_n), 16'hE);
            end
            if (c == 24) begin
                check("midrst f2 s1 bcd", 16'(bcd_out), 16'h0);
                check("midrst f2 s1 en", 16'(dig_en_n), 16'hD);
            end
        end
        check("midrst fd pulses", 16'(pulses), 16'd2);
        check("midrst fd slots", 16'(seen), 16'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, meaning clock cycles per digit slot (legal range >= 2).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port digits_in  input  16  four BCD digits; [3:0] = digit 0 (units), [15:12] = digit 3.
REQ-005 SHALL have port load  input  1  one-cycle strobe that captures digits_in.
REQ-006 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-007 SHALL have port bcd_out  output  4  BCD nibble to the downstream 7-segment decoder; [3] = w (MSB), [0] = z.
REQ-008 SHALL have port dig_en_n  output  4  active-low digit enables, one-hot-low; bit i selects digit i.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse when a 4-digit frame completes.
REQ-010 SHALL have port bcd_err  output  1  sticky flag for a non-BCD nibble (>9) in the displayed digits.

Function
REQ-011 SHALL run prescale counter pc over 0..PRESCALE-1 and wrap to 0; tick = (pc == PRESCALE-1).
REQ-012 SHALL, on tick, advance digit index idx 0->1->2->3->0 (2-bit wrap); idx SHALL hold otherwise.
REQ-013 SHALL define frame boundary as a tick with idx == 3.
REQ-014 SHALL pulse frame_done high for exactly the cycle after each frame boundary.
REQ-015 SHALL, on load with no frame boundary that cycle, write digits_in to pending register and set pend_v.
REQ-016 SHALL, on a frame boundary with pend_v = 1 and load = 0, copy pending into shadow and clear pend_v.
REQ-017 SHALL, on load coinciding with a frame boundary, write digits_in directly into shadow and clear pend_v.
REQ-018 SHALL keep last write on back-to-back loads within one frame; only the latest value reaches shadow.
REQ-019 SHALL source displayed digits only from shadow; a digit shall never change mid-frame (no tearing).
REQ-020 SHALL register bcd_out and dig_en_n; they SHALL reflect the new idx one cycle after tick (latency 1).
REQ-021 SHALL drive a non-blanked slot with bcd_out = shadow digit idx and dig_en_n[idx] = 0, other bits 1.
REQ-022 SHALL treat digit i (i = 3, 2, 1) as blanked when blank_lz = 1 and shadow digits i..3 are all zero.
REQ-023 SHALL never blank digit 0; value 0000 with blank_lz = 1 displays a single "0" on digit 0.
REQ-024 SHALL treat a digit > 9 as blanked and set bcd_err in the same cycle its slot is output.
REQ-025 SHALL, for a blanked slot, drive dig_en_n = 4'b1111 and bcd_out = 4'hF.
REQ-026 SHALL hold bcd_err at 1 until reset.
REQ-027 SHALL sample blank_lz every cycle; a change takes effect at the next slot output.

Reset
REQ-028 SHALL, while rst_n = 0 at a clock edge, set pc = 0, idx = 0, pending = 0, shadow = 0, pend_v = 0.
REQ-029 SHALL, on the same reset edge, set bcd_out = 4'h0, dig_en_n = 4'b1111, frame_done = 0, bcd_err = 0.
REQ-030 SHALL let reset mid-frame abort the frame, discard the pending load and restart at slot 0 with pc = 0.
REQ-031 SHALL ignore load in any cycle where rst_n = 0.
REQ-032 SHALL output first slot (digit 0 of shadow = 0) one cycle after the first tick following reset release.

Verification (PRESCALE = 4)
REQ-033 SHALL test: reset, load 16'h1234, run 2 frames -> from 2nd frame bcd_out cycles 4,3,2,1 with dig_en_n 1110,1101,1011,0111, each held 4 cycles.
REQ-034 SHALL test: blank_lz = 1, load 16'h0047 -> slots 0 and 1 show 7 and 4; slots 2 and 3 show dig_en_n = 1111, bcd_out = F.
REQ-035 SHALL test: load 16'h1111, then load 16'h2222 mid-frame and 16'h3333 two cycles later -> current frame stays 1s; next frame shows all 3s.
REQ-036 SHALL test: load 16'h5555 on frame-boundary cycle -> next frame shows 5s and pend_v = 0.
REQ-037 SHALL test: load 16'h00A0 -> slot 1 blanked, bcd_err rises on that slot and stays high across later valid loads until rst_n = 0.
REQ-038 SHALL test: assert rst_n = 0 during slot 2 with a pending load -> all outputs at reset values; after release shadow = 0 and frame_done pulses once per 16 cycles.
